// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan reader.
// Holds the segment code table, the blank code and the reader FSM states.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h00;

    // Segment code for nibbles 0..F, seg = {g,f,e,d,c,b,a}
    localparam seg7_t SEG_CODE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    // One {dig_sel, seg} sample of the display lines
    typedef struct packed {
        logic [3:0] sel;
        seg7_t      seg;
    } obs_t;

    // Forward encoding, shared with the bin_to_7_seg encoder
    function automatic seg7_t seg7_encode(input logic [3:0] nib);
        return SEG_CODE[nib];
    endfunction

    function automatic logic one_hot4(input logic [3:0] v);
        return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
    endfunction

    // Position of the hot bit; only meaningful when v is one-hot
    function automatic logic [1:0] sel_index(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational reverse lookup of a seven-segment code.
// Ports: seg (code in), legal (code is in the table), nibble (decoded value).
module seg7_to_nibble
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] nibble
);

    always_comb begin
        legal  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODE[i]) begin
                legal  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers the 16-bit value shown on a scanned 4-digit seven-segment display.
// Ports: clk, rst_n, segment lines a..g, dig_sel[3:0] in; value[15:0],
// digit_strobe, digit_idx[1:0], frame_valid, bad_pattern out.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        e,
    input  logic        f,
    input  logic        g,
    input  logic [3:0]  dig_sel,
    output logic [15:0] value,
    output logic        digit_strobe,
    output logic [1:0]  digit_idx,
    output logic        frame_valid,
    output logic        bad_pattern
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    obs_t       s;
    obs_t       s_prev;
    state_t     state;
    state_t     state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic       eval;

    logic [3:0]  seen;
    logic [3:0]  seen_upd;
    logic [3:0]  dig_q [4];
    logic [15:0] value_q;
    logic [15:0] frame_word;

    logic       s_valid;
    logic       s_changed;
    logic       dec_legal;
    logic [3:0] dec_nib;
    logic [1:0] idx;
    logic       capture;
    logic       frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s      <= '0;
            s_prev <= '0;
        end else begin
            s      <= {dig_sel, g, f, e, d, c, b, a};
            s_prev <= s;
        end
    end

    assign s_valid   = one_hot4(s.sel) && (s.seg != SEG_BLANK);
    assign s_changed = (s != s_prev);
    assign idx       = sel_index(s.sel);

    seg7_to_nibble u_dec (
        .seg    (s.seg),
        .legal  (dec_legal),
        .nibble (dec_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // A pattern is evaluated once, on the cycle its stability count
    // completes with the current sample still matching the previous one.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        eval    = 1'b0;
        if (!s_valid) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (s_changed) begin
            state_n = SETTLE;
            cnt_n   = '0;
        end else if (state != HOLD) begin
            if (cnt == CNT_LAST) begin
                eval    = 1'b1;
                state_n = HOLD;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + 8'd1;
            end
        end
    end

    assign capture  = eval && dec_legal;
    assign seen_upd = seen | (4'b0001 << idx);
    assign frame    = capture && (seen_upd == 4'hF);

    // Frame contents including the nibble being captured this cycle
    always_comb begin
        frame_word = value_q;
        for (int i = 0; i < 4; i++) begin
            if (capture && (idx == 2'(i))) begin
                frame_word[4*i +: 4] = dec_nib;
            end else begin
                frame_word[4*i +: 4] = dig_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen    <= '0;
            value_q <= '0;
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= '0;
            end
        end else if (capture) begin
            dig_q[idx] <= dec_nib;
            seen       <= frame ? 4'b0000 : seen_upd;
            if (frame) begin
                value_q <= frame_word;
            end
        end
    end

    // Completing frame is visible together with its strobe
    assign value        = frame ? frame_word : value_q;
    assign digit_strobe = capture;
    assign digit_idx    = capture ? idx : 2'd0;
    assign frame_valid  = frame;
    assign bad_pattern  = eval && !dec_legal;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader (default and STABLE_CYCLES=1).
// Vector table plus hand sequences; expected events go through queues.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a = 0, b = 0, c = 0, d = 0, e = 0, f = 0, g = 0;
    logic [3:0]  dsel0 = 4'b0;
    logic [3:0]  dsel1 = 4'b0;

    logic [15:0] val0, val1;
    logic        ds0, ds1, fv0, fv1, bp0, bp1;
    logic [1:0]  di0, di1;

    always #5 clk = ~clk;

    seg7_scan_reader u0 (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .dig_sel(dsel0), .value(val0), .digit_strobe(ds0),
        .digit_idx(di0), .frame_valid(fv0), .bad_pattern(bp0)
    );

    seg7_scan_reader #(.STABLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .dig_sel(dsel1), .value(val1), .digit_strobe(ds1),
        .digit_idx(di1), .frame_valid(fv1), .bad_pattern(bp1)
    );

    typedef struct {
        int          cyc;
        logic        bad;
        logic [1:0]  idx;
        logic        frame;
        logic [15:0] value;
    } ev_t;

    typedef struct {
        int         grp;
        logic [3:0] dsel;
        logic [6:0] seg;
        int         hold;
        int         kind;   // 0 none, 1 strobe, 2 bad_pattern
        logic [1:0] idx;
        logic [3:0] nib;
    } vec_t;

    ev_t  q0[$];
    ev_t  q1[$];
    vec_t tbl[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [3:0]  mdig [2][4];
    logic [3:0]  mseen [2];
    logic [15:0] mval [2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int w);
        return (w == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ev_t front(input int w);
        return (w == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int w, output ev_t h);
        if (w == 0) h = q0.pop_front();
        else h = q1.pop_front();
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            mseen[w] = 4'b0;
            mval[w]  = 16'h0;
            for (int i = 0; i < 4; i++) mdig[w][i] = 4'h0;
        end
    endtask

    task automatic mon(input int w, input logic st, input logic bd,
                       input logic fv, input logic [1:0] di,
                       input logic [15:0] val);
        ev_t h;
        while (qsize(w) > 0 && front(w).cyc < cyc) begin
            qpop(w, h);
            n_chk++;
            n_fail++;
            $display("FAIL missed_event dut%0d: got none expected cycle %0d",
                     w, h.cyc);
        end
        if (fv && !st) chk("frame_without_strobe", 32'(fv), 32'(0));
        if (st || bd) begin
            chk("strobe_bad_exclusive", 32'(st & bd), 32'(0));
            if (qsize(w) == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event dut%0d: got st=%0d bad=%0d expected none (cycle %0d)",
                         w, st, bd, cyc);
            end else begin
                qpop(w, h);
                chk("event_cycle", 32'(cyc), 32'(h.cyc));
                chk("event_is_bad", 32'(bd), 32'(h.bad));
                if (!h.bad) chk("digit_idx", 32'(di), 32'(h.idx));
                chk("frame_valid", 32'(fv), 32'(h.frame));
                chk("value", 32'(val), 32'(h.value));
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        #2;
        mon(0, ds0, bp0, fv0, di0, val0);
        mon(1, ds1, bp1, fv1, di1, val1);
    end

    // Drive one pattern for 'hold' cycles; called just after a rising edge
    task automatic apply(input int w, input logic [3:0] dsel,
                         input logic [6:0] seg, input int hold,
                         input int kind, input logic [1:0] idx,
                         input logic [3:0] nib);
        ev_t ev;
        if (w == 0) dsel0 = dsel;
        else dsel1 = dsel;
        {g, f, e, d, c, b, a} = seg;
        if (kind != 0) begin
            ev.cyc   = cyc + 1 + ((w == 0) ? 4 : 1);
            ev.bad   = (kind == 2);
            ev.idx   = idx;
            ev.frame = 1'b0;
            if (kind == 1) begin
                mdig[w][idx]  = nib;
                mseen[w][idx] = 1'b1;
                if (mseen[w] == 4'hF) begin
                    mval[w]  = {mdig[w][3], mdig[w][2], mdig[w][1], mdig[w][0]};
                    mseen[w] = 4'h0;
                    ev.frame = 1'b1;
                end
            end
            ev.value = mval[w];
            if (w == 0) q0.push_back(ev);
            else q1.push_back(ev);
        end
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic run_grp(input int grp);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].grp == grp)
                apply(0, tbl[i].dsel, tbl[i].seg, tbl[i].hold,
                      tbl[i].kind, tbl[i].idx, tbl[i].nib);
        end
    endtask

    function automatic vec_t vec(input int grp, input logic [3:0] dsel,
                                 input logic [6:0] seg, input int hold,
                                 input int kind, input logic [1:0] idx,
                                 input logic [3:0] nib);
        vec_t v;
        v.grp = grp; v.dsel = dsel; v.seg = seg; v.hold = hold;
        v.kind = kind; v.idx = idx; v.nib = nib;
        return v;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_value"}, 32'(val0), 32'(0));
        chk({tag, "_strobe"}, 32'(ds0), 32'(0));
        chk({tag, "_idx"}, 32'(di0), 32'(0));
        chk({tag, "_frame"}, 32'(fv0), 32'(0));
        chk({tag, "_bad"}, 32'(bp0), 32'(0));
    endtask

    initial begin
        // full frame: 3, 8, A, C
        tbl.push_back(vec(0, 4'b0001, 7'h4F, 8, 1, 2'd0, 4'h3));
        tbl.push_back(vec(0, 4'b0010, 7'h7F, 8, 1, 2'd1, 4'h8));
        tbl.push_back(vec(0, 4'b0100, 7'h77, 8, 1, 2'd2, 4'hA));
        tbl.push_back(vec(0, 4'b1000, 7'h39, 8, 1, 2'd3, 4'hC));
        // glitches inside settle windows, illegal, blank, bad selects
        tbl.push_back(vec(1, 4'b0010, 7'h5B, 2, 0, 2'd0, 4'h0));
        tbl.push_back(vec(1, 4'b0010, 7'h66, 1, 0, 2'd0, 4'h0));
        tbl.push_back(vec(1, 4'b0010, 7'h5B, 8, 1, 2'd1, 4'h2));
        tbl.push_back(vec(1, 4'b0100, 7'h77, 3, 0, 2'd0, 4'h0));
        tbl.push_back(vec(1, 4'b0100, 7'h00, 1, 0, 2'd0, 4'h0));
        tbl.push_back(vec(1, 4'b0100, 7'h77, 8, 1, 2'd2, 4'hA));
        tbl.push_back(vec(1, 4'b0100, 7'h49, 8, 2, 2'd2, 4'h0));
        tbl.push_back(vec(1, 4'b0100, 7'h00, 8, 0, 2'd0, 4'h0));
        tbl.push_back(vec(1, 4'b0110, 7'h3F, 8, 0, 2'd0, 4'h0));
        // rescan after long hold, then another frame
        tbl.push_back(vec(2, 4'b0001, 7'h7D, 8, 1, 2'd0, 4'h6));
        tbl.push_back(vec(2, 4'b0010, 7'h6D, 8, 1, 2'd1, 4'h5));
        tbl.push_back(vec(2, 4'b0100, 7'h07, 8, 1, 2'd2, 4'h7));
        tbl.push_back(vec(2, 4'b1000, 7'h6F, 8, 1, 2'd3, 4'h9));
        tbl.push_back(vec(2, 4'b1000, 7'h71, 8, 1, 2'd3, 4'hF));
        tbl.push_back(vec(2, 4'b0100, 7'h79, 8, 1, 2'd2, 4'hE));
        tbl.push_back(vec(2, 4'b0010, 7'h5E, 8, 1, 2'd1, 4'hD));
        tbl.push_back(vec(2, 4'b0001, 7'h7C, 8, 1, 2'd0, 4'hB));

        model_reset();
        #3;
        chk_outputs_zero("reset");
        chk("reset_value_u1", 32'(val1), 32'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_grp(0);
        chk("frame_value_hold", 32'(val0), 32'(16'hCA83));

        // partial frame, then reset in the middle of a settle window
        apply(0, 4'b0010, 7'h3F, 8, 1, 2'd1, 4'h0);
        apply(0, 4'b0001, 7'h06, 2, 0, 2'd0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        apply(0, 4'b0001, 7'h06, 8, 1, 2'd0, 4'h1);

        run_grp(1);

        // steadily lit digit is captured once
        apply(0, 4'b0010, 7'h6D, 100, 1, 2'd1, 4'h5);
        run_grp(2);

        // STABLE_CYCLES=1: back-to-back alternating digits
        apply(0, 4'b0000, 7'h00, 3, 0, 2'd0, 4'h0);
        apply(1, 4'b0001, 7'h4F, 2, 1, 2'd0, 4'h3);
        apply(1, 4'b0010, 7'h66, 2, 1, 2'd1, 4'h4);
        apply(1, 4'b0001, 7'h5B, 2, 1, 2'd0, 4'h2);
        apply(1, 4'b0010, 7'h6D, 2, 1, 2'd1, 4'h5);
        apply(1, 4'b0100, 7'h7D, 2, 1, 2'd2, 4'h6);
        apply(1, 4'b1000, 7'h07, 2, 1, 2'd3, 4'h7);
        apply(1, 4'b0000, 7'h00, 12, 0, 2'd0, 4'h0);

        chk("u1_final_value", 32'(val1), 32'(16'h7652));
        chk("u0_final_value", 32'(val0), 32'(16'hFEDB));
        chk("pending_u0", 32'(q0.size()), 32'(0));
        chk("pending_u1", 32'(q1.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Recovers the hexadecimal value shown on a multiplexed 4-digit seven-segment display by watching its segment lines (a–g) and digit selects. It is the reverse path of the `bin_to_7_seg` decoder: segment patterns in, 4-bit nibbles out. Each pattern is debounced, decoded and checked, then assembled into a 16-bit word. The block is used for display loop-back self-check and for scoreboarding in the ToyProcessor design.

## Interface
Parameters:
- STABLE_CYCLES, 4: extra sampling edges a pattern must stay unchanged before capture; legal range 1–255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- a, b, c, d, e, f, g  in  1 each  segment lines; active-high; synchronous to clk.
- dig_sel  in  4  digit enables; active-high; one-hot when valid; bit i selects digit i.
- value  out  16  last complete frame; digit i is value[4i+3:4i].
- digit_strobe  out  1  one-cycle pulse: a digit was captured.
- digit_idx  out  2  index of the captured digit; valid while digit_strobe is high.
- frame_valid  out  1  one-cycle pulse: value was just updated.
- bad_pattern  out  1  one-cycle pulse: a stable, selected pattern is not a legal code.

## Operation
- Pattern code: seg = {g,f,e,d,c,b,a}, with a as bit 0.
- Legal codes, nibbles 0–F in order: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- Input register: {dig_sel, seg} is sampled every edge into s. The previous sample is s_prev.
- An observation is valid when dig_sel is exactly one-hot and seg ≠ 00.
  - seg = 00 is blank: no capture and no error.
  - Zero or multiple hot selects: no capture and no error.
- Three states:
  - IDLE: s is invalid. Stay in IDLE. cnt = 0.
  - SETTLE: s is valid and differs from s_prev → cnt = 0. s equals s_prev → cnt increments. At cnt == STABLE_CYCLES−1 with s still equal to s_prev, evaluate and go to HOLD.
  - HOLD: stay while s is unchanged. No further captures, so a steadily lit digit is captured once. Any change → SETTLE if the new s is valid, else IDLE.
  - Any change in s, or s becoming invalid, restarts counting from SETTLE/IDLE.
- Evaluate, legal code:
  - Write the nibble into digit register digit_idx.
  - Set seen[digit_idx].
  - Pulse digit_strobe.
- Evaluate, illegal code: pulse bad_pattern only. No register write and no seen update.
- Frame completion: when a capture makes seen = 4'b1111, in the same cycle:
  - Load value from the four digit registers, including the nibble just captured.
  - Pulse frame_valid.
  - Clear seen to 0000.
- A digit captured twice before the frame completes overwrites its register. seen is unaffected.
- value holds between frames.

## Timing
- Reset (asynchronous, rst_n low): all outputs 0. s, cnt, seen and digit registers are 0. State is IDLE.
- Reset asserted mid-frame discards the partial frame. value returns to 0.
- Latency: pattern first registered at edge E0 and unchanged through edge E0+STABLE_CYCLES → digit_strobe or bad_pattern is high for the cycle after edge E0+STABLE_CYCLES.
- With the default, that is the 5th sampling edge.
- frame_valid coincides with the digit_strobe of the completing digit. value is updated on that same edge.
- Minimum spacing between strobes is STABLE_CYCLES+1 cycles.
- A pattern change on the evaluation edge itself aborts the capture.
- digit_strobe and bad_pattern are never high together.

## Structure
- Package seg7_pkg:
  - SEG_CODE[16] lookup constant.
  - SEG_BLANK = 7'h00.
  - typedef seg7_t (7-bit).
  - State enum {IDLE, SETTLE, HOLD}.
- The bin_to_7_seg encoder reuses SEG_CODE.
- Sub-module seg7_to_nibble: combinational reverse lookup, seg7_t → {legal, nibble[3:0]}.
- seg7_scan_reader holds the input register, FSM, counter, seen mask and digit registers.

## Test plan
- Reset: rst_n low mid-SETTLE → all outputs 0 immediately. Release, then hold dig_sel=0001 with seg=06 → digit_strobe with digit_idx=0 after 5 edges, frame_valid stays 0.
- Full frame: digits 0..3 = 4F, 7F, 77, 39, each held 8 cycles → four strobes, one frame_valid on the digit-3 strobe, value=16'hCA83.
- Glitch: seg changes for 1 cycle inside a settle window → count restarts, capture delayed accordingly, no bad_pattern.
- Illegal/blank: seg=7'h49 held with dig_sel=0100 → one bad_pattern, seen unchanged. seg=00 → nothing. dig_sel=0110 → nothing.
- Hold/rescan: dig_sel=0010 with seg=6D held 100 cycles → exactly one strobe. Then rescan all four → value nibble 1 = 5.
- STABLE_CYCLES=1 build: strobe 2 edges after first sample. Back-to-back alternating digits capture correctly.
